instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/isa_pkg.sv | 26 ++
 rtl/instr_encode.sv | 26 ++
 rtl/instr_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isa_pkg
// Description : ALU op codes, instruction field positions and field struct.
// Revision    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    localparam int INSTR_W = 32;
    localparam int OP_LSB  = 27;
    localparam int RS1_LSB = 21;
    localparam int RS2_LSB = 16;
    localparam int RD_LSB  = 11;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } instr_fields_t;

endpackage
`default_nettype wire

// File: rtl/instr_encode.sv
`default_nettype none
// ============================================================================
// Module      : instr_encode
// Description : Packs instruction fields into a 32-bit word; flags legal ops.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encode
    import isa_pkg::*;
(
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output logic          op_legal
);

    always_comb begin
        word                    = '0;
        word[31]                = 1'b1;
        word[OP_LSB  +: 3]      = fields.op;
        word[RS1_LSB +: 5]      = fields.rs1;
        word[RS2_LSB +: 5]      = fields.rs2;
        word[RD_LSB  +: 5]      = fields.rd;
        op_legal                = (fields.op == OP_ADD) || (fields.op == OP_SUB);
    end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Loads encoded ALU instructions into a buffer, then issues them
//               one per handshake to a downstream datapath on start.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [2:0]                 ld_op,
    input  logic [4:0]                 ld_rs1,
    input  logic [4:0]                 ld_rs2,
    input  logic [4:0]                 ld_rd,
    input  logic                       start,
    input  logic                       clear,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            err_q, err_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [31:0]     prog_q [DEPTH];

    instr_fields_t   ld_fields;
    logic [31:0]     enc_word;
    logic            enc_legal;
    logic            prog_we;
    logic [PW-1:0]   ptr_next;
    logic            last_entry;

    assign ld_fields = '{op: ld_op, rs1: ld_rs1, rs2: ld_rs2, rd: ld_rd};

    instr_encode u_encode (
        .fields   (ld_fields),
        .word     (enc_word),
        .op_legal (enc_legal)
    );

    assign ld_ready   = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !start && !clear;
    assign ptr_next   = ptr_q + PW'(1);
    assign last_entry = (CW'(ptr_q) == (count_q - CW'(1)));

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        ptr_d        = ptr_q;
        err_d        = err_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        prog_we      = 1'b0;
        case (state_q)
            IDLE: begin
                // start outranks clear and load; ld_ready already excludes both
                if (start) begin
                    if (count_q != '0) begin
                        state_d      = ISSUE;
                        ptr_d        = '0;
                        busy_d       = 1'b1;
                        inst_valid_d = 1'b1;
                        inst_d       = prog_q[0];
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (clear) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (ld_valid && ld_ready) begin
                    if (enc_legal) begin
                        prog_we = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (inst_ready) begin
                    if (last_entry) begin
                        state_d      = DONE;
                        inst_valid_d = 1'b0;
                        inst_d       = '0;
                        done_d       = 1'b1;
                    end else begin
                        ptr_d  = ptr_next;
                        inst_d = prog_q[ptr_next];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            ptr_q        <= '0;
            err_q        <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ptr_q        <= ptr_d;
            err_q        <= err_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Program storage carries no reset; count_q alone decides what is reachable.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            prog_q[count_q[PW-1:0]] <= enc_word;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire
